riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu.sv | 165 ++++++++++++++++
 tb/tb_riscv_lsu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit: aligns core accesses onto a 32-bit data memory port,
// formats load data, and stalls the core for the duration of each access.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;

  logic        legal_c, aligned_c;
  logic [3:0]  be_c;
  logic [31:0] wd_fmt_c, rd_fmt_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Request decode: legality, alignment, lane enables and replicated store data.
  always_comb begin
    legal_c   = 1'b0;
    aligned_c = 1'b1;
    case (core_size_i)
      LDST_B:  legal_c = 1'b1;
      LDST_BU: legal_c = ~core_we_i;
      LDST_H: begin
        legal_c   = 1'b1;
        aligned_c = ~core_addr_i[0];
      end
      LDST_HU: begin
        legal_c   = ~core_we_i;
        aligned_c = ~core_addr_i[0];
      end
      LDST_W: begin
        legal_c   = 1'b1;
        aligned_c = (core_addr_i[1:0] == 2'b00);
      end
      default: legal_c = 1'b0;
    endcase

    case (core_size_i[1:0])
      2'd0: begin
        be_c     = 4'b0001 << core_addr_i[1:0];
        wd_fmt_c = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        be_c     = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_fmt_c = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_c     = 4'b1111;
        wd_fmt_c = core_wd_i;
      end
    endcase
  end

  // Load formatting from the latched size and byte offset.
  always_comb begin
    byte_c = mem_rd_i[{addr_q[1:0], 3'b000} +: 8];
    half_c = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      LDST_B:  rd_fmt_c = {{24{byte_c[7]}}, byte_c};
      LDST_BU: rd_fmt_c = {24'h000000, byte_c};
      LDST_H:  rd_fmt_c = {{16{half_c[15]}}, half_c};
      LDST_HU: rd_fmt_c = {16'h0000, half_c};
      default: rd_fmt_c = mem_rd_i;
    endcase
  end

  // Next-state and handshake outputs; IDLE outputs are gated by reset
  // because they depend directly on core inputs.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wd_d         = wd_q;
    rd_d         = rd_q;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_be_o     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (legal_c && aligned_c) begin
            core_stall_o = arstn_i;
            we_d         = core_we_i;
            size_d       = core_size_i;
            addr_d       = core_addr_i;
            be_d         = be_c;
            wd_d         = wd_fmt_c;
            state_d      = BUSY;
          end else begin
            core_err_o = arstn_i;
          end
        end
      end
      BUSY: begin
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_be_o     = be_q;
        if (mem_ready_i) begin
          state_d = DONE;
          if (!we_q) rd_d = rd_fmt_c;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wd_q    <= 32'h0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end

  assign core_rd_o  = rd_q;
  assign mem_we_o   = we_q;
  assign mem_addr_o = {addr_q[31:2], 2'b00};
  assign mem_wd_o   = wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: the driver queues expected memory
// transactions and error pulses, and a negedge monitor checks them.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, core_rd_o;
  logic        core_stall_o, core_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_ready_i;

  riscv_lsu dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .core_err_o(core_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_err;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: DUT output with no matching expectation", name);
  endtask

  // Monitor: pops one expectation per completed access or error pulse.
  int   stall_cnt    = 0;
  logic done_pending = 1'b0;
  exp_t m_e;
  always @(negedge clk_i) begin
    if (!arstn_i) begin
      stall_cnt    = 0;
      done_pending = 1'b0;
    end else begin
      if (done_pending) begin
        done_pending = 1'b0;
        if (sb_q.size() == 0) fail_now("done_unexpected");
        else begin
          m_e = sb_q.pop_front();
          check("rd", core_rd_o, m_e.rd);
          check("done_stall", 32'(core_stall_o), 32'd0);
          check("done_req", 32'(mem_req_o), 32'd0);
          check("done_be", 32'(mem_be_o), 32'd0);
          check("stall_cycles", 32'(stall_cnt), 32'(m_e.stall));
        end
        stall_cnt = 0;
      end
      if (core_stall_o) stall_cnt++;
      if (core_err_o) begin
        if (sb_q.size() == 0 || !sb_q[0].is_err) fail_now("err_unexpected");
        else begin
          m_e = sb_q.pop_front();
          check("err_req", 32'(mem_req_o), 32'd0);
          check("err_stall", 32'(core_stall_o), 32'd0);
        end
        stall_cnt = 0;
      end
      if (mem_req_o) begin
        if (sb_q.size() == 0 || sb_q[0].is_err) fail_now("req_unexpected");
        else begin
          check("mem_we", 32'(mem_we_o), 32'(sb_q[0].we));
          check("mem_be", 32'(mem_be_o), 32'(sb_q[0].be));
          check("mem_addr", mem_addr_o, sb_q[0].addr);
          check("mem_wd", mem_wd_o, sb_q[0].wd);
          if (mem_ready_i) done_pending = 1'b1;
        end
      end
    end
  end

  // Legal access; wait_n BUSY cycles with ready low before the ready cycle.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int wait_n,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd,
                        input int estall);
    exp_t e;
    e.is_err = 1'b0; e.we = we; e.be = ebe; e.addr = {addr[31:2], 2'b00};
    e.wd = ewd; e.rd = erd; e.stall = estall;
    sb_q.push_back(e);
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd; mem_ready_i = 1'b0; mem_rd_i = 32'h5555_AAAA;
    @(posedge clk_i); #1;
    // Core inputs wander while BUSY and must not disturb the access.
    core_we_i = ~we; core_size_i = 3'd2; core_addr_i = $urandom; core_wd_i = $urandom;
    mem_rd_i = rdata;
    repeat (wait_n) begin @(posedge clk_i); #1; end
    mem_ready_i = 1'b1; core_req_i = 1'b0;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
  endtask

  // Illegal or misaligned request with a stray ready that must be ignored.
  task automatic bad(input logic we, input logic [2:0] size, input logic [31:0] addr);
    exp_t e;
    e.is_err = 1'b1; e.we = we; e.be = 4'h0; e.addr = addr; e.wd = 32'h0; e.rd = 32'h0; e.stall = 0;
    sb_q.push_back(e);
    core_req_i = 1'b1; core_we_i = we; core_size_i = size; core_addr_i = addr;
    core_wd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    core_req_i = 1'b0; mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    arstn_i = 1'b0; core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
    core_addr_i = 32'h0; core_wd_i = 32'hFFFF_FFFF; mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1;
    #3;
    check("rst_stall", 32'(core_stall_o), 32'd0);
    check("rst_err", 32'(core_err_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_be", 32'(mem_be_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wd", mem_wd_o, 32'd0);
    check("rst_rd", core_rd_o, 32'd0);
    @(posedge clk_i); #1;
    core_req_i = 1'b0; mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    arstn_i = 1'b1;

    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 0, 4'b1000, 32'h0, 32'h0000_0080, 2);
    access(1'b0, 3'd1, 32'h102, 32'h0, 32'h8001_0000, 0, 4'b1100, 32'h0, 32'hFFFF_8001, 2);
    access(1'b1, 3'd0, 32'h001, 32'h1234_56AB, 32'h0, 0, 4'b0010, 32'hABAB_ABAB, 32'hFFFF_8001, 2);
    // Ready low in the request cycle plus four BUSY cycles: five low cycles, six stalled.
    access(1'b1, 3'd2, 32'h040, 32'hDEAD_BEEF, 32'h0, 4, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_8001, 6);
    access(1'b0, 3'd0, 32'h001, 32'h0, 32'h1234_8056, 1, 4'b0010, 32'h0, 32'hFFFF_FF80, 3);
    access(1'b0, 3'd5, 32'h002, 32'h0, 32'hBEEF_0000, 0, 4'b1100, 32'h0, 32'h0000_BEEF, 2);
    access(1'b0, 3'd2, 32'h010, 32'h0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0, 32'hCAFE_F00D, 2);
    access(1'b1, 3'd1, 32'h002, 32'h0000_5A5A, 32'h0, 0, 4'b1100, 32'h5A5A_5A5A, 32'hCAFE_F00D, 2);

    bad(1'b0, 3'd2, 32'h002);
    bad(1'b0, 3'd3, 32'h000);
    bad(1'b1, 3'd4, 32'h000);
    bad(1'b0, 3'd1, 32'h001);
    bad(1'b0, 3'd7, 32'h000);

    // Reset in BUSY: outputs drop without a clock edge, no completion.
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h200;
    mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
    check("busy_req_pre", 32'(mem_req_o), 32'd1);
    arstn_i = 1'b0;
    #1;
    check("abort_req", 32'(mem_req_o), 32'd0);
    check("abort_stall", 32'(core_stall_o), 32'd0);
    check("abort_be", 32'(mem_be_o), 32'd0);
    check("abort_rd", core_rd_o, 32'd0);
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    arstn_i = 1'b1;
    access(1'b0, 3'd2, 32'h204, 32'h0, 32'h1122_3344, 0, 4'b1111, 32'h0, 32'h1122_3344, 2);

    repeat (3) @(posedge clk_i);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
